// File: rtl/branch_predictor_bht_if.sv
// Fetch/EX-side bundle for the branch history table: lookup, resolved-branch
// update and statistics. The pipeline is the master, the predictor the slave.
interface branch_predictor_bht_if #(
  parameter int WORD = 32
);
  logic [WORD-1:0] lk_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [WORD-1:0] pred_target;

  logic            upd_valid;
  logic            upd_is_branch;
  logic [WORD-1:0] upd_pc;
  logic            upd_taken;
  logic [WORD-1:0] upd_target;
  logic            upd_mispredict;

  logic [31:0]     stat_br;
  logic [31:0]     stat_mis;

  modport master (
    output lk_pc, upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_hit, pred_taken, pred_target, stat_br, stat_mis
  );

  modport slave (
    input  lk_pc, upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_hit, pred_taken, pred_target, stat_br, stat_mis
  );
endinterface

// File: rtl/branch_predictor_bht.sv
// Direct-mapped, tagged branch history table with saturating counters,
// zero-latency lookup and single-port resolved-branch update.
module branch_predictor_bht #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int TAG_W   = 8,
  parameter int WORD    = 32
) (
  input logic                   clk,
  input logic                   rst,
  branch_predictor_bht_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_ONE << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_ONE;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  logic             valid_q [ENTRIES];
  tag_t             tag_q   [ENTRIES];
  logic [CNT_W-1:0] cnt_q   [ENTRIES];
  logic [WORD-1:0]  tgt_q   [ENTRIES];
  logic [31:0]      stat_br_q, stat_mis_q;

  // Lookup path: purely combinational, sees only committed table state.
  idx_t lk_idx;
  tag_t lk_tag;
  logic lk_hit;
  logic lk_taken;

  assign lk_idx   = bus.lk_pc[IDX_W+1:2];
  assign lk_tag   = bus.lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit   = !rst && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && cnt_q[lk_idx][CNT_W-1];

  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_taken;
  assign bus.pred_target = lk_taken ? tgt_q[lk_idx] : bus.lk_pc + WORD'(4);
  assign bus.stat_br     = stat_br_q;
  assign bus.stat_mis    = stat_mis_q;

  // Update path: one entry may be rewritten per cycle.
  idx_t             upd_idx;
  tag_t             upd_tag;
  logic             upd_en;
  logic             upd_hit;
  logic             ent_wr;
  logic             ent_valid_d;
  tag_t             ent_tag_d;
  logic [CNT_W-1:0] ent_cnt_d;
  logic [WORD-1:0]  ent_tgt_d;
  logic [31:0]      stat_br_d, stat_mis_d;
  logic             unused_upd_pc;

  assign upd_idx       = bus.upd_pc[IDX_W+1:2];
  assign upd_tag       = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_en        = bus.upd_valid && bus.upd_is_branch;
  assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign unused_upd_pc = ^bus.upd_pc;

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves one unassigned and no latch is inferred.
    ent_wr      = 1'b0;
    ent_valid_d = valid_q[upd_idx];
    ent_tag_d   = tag_q[upd_idx];
    ent_cnt_d   = cnt_q[upd_idx];
    ent_tgt_d   = tgt_q[upd_idx];
    stat_br_d   = stat_br_q;
    stat_mis_d  = stat_mis_q;

    if (upd_en) begin
      if (upd_hit) begin
        ent_wr = 1'b1;
        if (bus.upd_taken) begin
          ent_cnt_d = (cnt_q[upd_idx] == CNT_MAX) ? CNT_MAX : cnt_q[upd_idx] + CNT_ONE;
          ent_tgt_d = bus.upd_target;
        end else begin
          ent_cnt_d = (cnt_q[upd_idx] == '0) ? '0 : cnt_q[upd_idx] - CNT_ONE;
        end
      end else if (bus.upd_taken) begin
        // Allocation on a taken miss replaces whatever held this index.
        ent_wr      = 1'b1;
        ent_valid_d = 1'b1;
        ent_tag_d   = upd_tag;
        ent_cnt_d   = CNT_WT;
        ent_tgt_d   = bus.upd_target;
      end

      if (stat_br_q != '1) stat_br_d = stat_br_q + 32'd1;
      if (bus.upd_mispredict && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + 32'd1;
    end
  end

  // NOTE: the table is built from flops rather than RAM because reset must
  // clear every entry at once; a RAM macro could not be reset this way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= CNT_WNT;
        tgt_q[i]   <= '0;
      end
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all state updating together on the
      // edge, so the lookup never observes a half-written entry.
      if (ent_wr) begin
        valid_q[upd_idx] <= ent_valid_d;
        tag_q[upd_idx]   <= ent_tag_d;
        cnt_q[upd_idx]   <= ent_cnt_d;
        tgt_q[upd_idx]   <= ent_tgt_d;
      end
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboarded bench for branch_predictor_bht: directed scenarios plus random
// traffic, compared against an arithmetic model of the table.
module tb_branch_predictor_bht;

  localparam int M_ENTRIES = 64;
  localparam int M_TAGS    = 256;
  localparam int M_CMAX    = 3;
  localparam int M_WT      = 2;
  localparam int M_WNT     = 1;

  logic clk;
  logic rst;

  branch_predictor_bht_if #(.WORD(32)) bus ();

  branch_predictor_bht #(
    .ENTRIES(64), .CNT_W(2), .TAG_W(8), .WORD(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: the table as plain arrays, indexed by pc arithmetic.
  bit          m_valid [M_ENTRIES];
  int          m_tag   [M_ENTRIES];
  int          m_cnt   [M_ENTRIES];
  logic [31:0] m_tgt   [M_ENTRIES];
  logic [31:0] m_br, m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % M_ENTRIES);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc / (4 * M_ENTRIES)) % M_TAGS);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < M_ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_cnt[i]   = M_WNT;
      m_tgt[i]   = '0;
    end
    m_br  = '0;
    m_mis = '0;
  endfunction

  typedef struct {
    int          id;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [31:0] br;
    logic [31:0] mis;
  } exp_t;

  exp_t sb[$];
  int   cyc_id = 0;

  function automatic exp_t predict(input logic [31:0] pc);
    exp_t e;
    int   i;
    i        = idx_of(pc);
    e.id     = cyc_id;
    e.hit    = m_valid[i] && (m_tag[i] == tag_of(pc));
    e.taken  = e.hit && (m_cnt[i] >= M_WT);
    e.target = e.taken ? m_tgt[i] : pc + 32'd4;
    e.br     = m_br;
    e.mis    = m_mis;
    return e;
  endfunction

  function automatic void model_update(input bit v, input bit br, input logic [31:0] pc,
                                       input bit tk, input logic [31:0] tgt, input bit mis);
    int i;
    if (!(v && br)) return;
    i = idx_of(pc);
    if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
    if (mis && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
    if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
      if (tk) begin
        m_cnt[i] = (m_cnt[i] < M_CMAX) ? m_cnt[i] + 1 : M_CMAX;
        m_tgt[i] = tgt;
      end else begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(pc);
      m_tgt[i]   = tgt;
      m_cnt[i]   = M_WT;
    end
  endfunction

  // One clock cycle of stimulus: lookup plus optional update.
  task automatic cycle(input logic [31:0] lk, input bit v, input bit br, input logic [31:0] pc,
                       input bit tk, input logic [31:0] tgt, input bit mis);
    @(posedge clk);
    #1;
    bus.lk_pc          = lk;
    bus.upd_valid      = v;
    bus.upd_is_branch  = br;
    bus.upd_pc         = pc;
    bus.upd_taken      = tk;
    bus.upd_target     = tgt;
    bus.upd_mispredict = mis;
    cyc_id++;
    sb.push_back(predict(lk));
    model_update(v, br, pc, tk, tgt, mis);
  endtask

  task automatic look(input logic [31:0] lk);
    cycle(lk, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] lk, input logic [31:0] pc, input bit tk,
                     input logic [31:0] tgt, input bit mis);
    cycle(lk, 1'b1, 1'b1, pc, tk, tgt, mis);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("pred_hit#%0d", e.id),    {31'd0, bus.pred_hit},   {31'd0, e.hit});
        check($sformatf("pred_taken#%0d", e.id),  {31'd0, bus.pred_taken}, {31'd0, e.taken});
        check($sformatf("pred_target#%0d", e.id), bus.pred_target,         e.target);
        check($sformatf("stat_br#%0d", e.id),     bus.stat_br,             e.br);
        check($sformatf("stat_mis#%0d", e.id),    bus.stat_mis,            e.mis);
      end
    end
  end

  // Reset asserted between edges with a coincident update; checks are immediate.
  task automatic reset_mid_cycle();
    @(negedge clk);
    #2;
    rst                = 1'b1;
    bus.lk_pc          = 32'h1C00_0080;
    bus.upd_valid      = 1'b1;
    bus.upd_is_branch  = 1'b1;
    bus.upd_pc         = 32'h1C00_0080;
    bus.upd_taken      = 1'b1;
    bus.upd_target     = 32'h1C00_0300;
    bus.upd_mispredict = 1'b1;
    #1;
    check("rst_stat_br",     bus.stat_br,                 32'd0);
    check("rst_stat_mis",    bus.stat_mis,                32'd0);
    check("rst_pred_hit",    {31'd0, bus.pred_hit},       32'd0);
    check("rst_pred_taken",  {31'd0, bus.pred_taken},     32'd0);
    check("rst_pred_target", bus.pred_target,             32'h1C00_0084);
    @(posedge clk);
    #1;
    check("rst_hold_stat_br", bus.stat_br,                32'd0);
    check("rst_hold_hit",     {31'd0, bus.pred_hit},      32'd0);
    #2;
    rst           = 1'b0;
    bus.upd_valid = 1'b0;
    model_reset();
  endtask

  logic [31:0] r_lk, r_pc;
  bit          r_v, r_b, r_t, r_m;
  int          drain;

  initial begin
    rst                = 1'b1;
    bus.lk_pc          = 32'h1C00_0040;
    bus.upd_valid      = 1'b0;
    bus.upd_is_branch  = 1'b0;
    bus.upd_pc         = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_target     = '0;
    bus.upd_mispredict = 1'b0;
    model_reset();
    #1;
    check("init_pred_hit",    {31'd0, bus.pred_hit},   32'd0);
    check("init_pred_taken",  {31'd0, bus.pred_taken}, 32'd0);
    check("init_pred_target", bus.pred_target,         32'h1C00_0044);
    #11;
    rst = 1'b0;

    // Allocation, saturation and decay on one entry; same-cycle lookup sees old state.
    look(32'h1C00_0040);
    upd (32'h1C00_0040, 32'h1C00_0040, 1'b1, 32'h1C00_0100, 1'b0);
    upd (32'h1C00_0040, 32'h1C00_0040, 1'b1, 32'h1C00_0100, 1'b0);
    upd (32'h1C00_0040, 32'h1C00_0040, 1'b1, 32'h1C00_0100, 1'b0);
    upd (32'h1C00_0040, 32'h1C00_0040, 1'b0, 32'h1C00_0999, 1'b1);
    upd (32'h1C00_0040, 32'h1C00_0040, 1'b0, 32'h1C00_0999, 1'b0);
    look(32'h1C00_0040);
    // Alias at the same index with a different tag replaces the entry.
    look(32'h1C00_0140);
    upd (32'h1C00_0140, 32'h1C00_0140, 1'b1, 32'h1C00_0200, 1'b0);
    look(32'h1C00_0140);
    look(32'h1C00_0040);
    // Not-taken miss leaves the table alone; gated updates change nothing.
    upd (32'h1C00_0010, 32'h1C00_0010, 1'b0, 32'h1C00_0500, 1'b1);
    look(32'h1C00_0010);
    cycle(32'h1C00_0020, 1'b1, 1'b0, 32'h1C00_0020, 1'b1, 32'h1C00_0600, 1'b1);
    cycle(32'h1C00_0020, 1'b0, 1'b1, 32'h1C00_0020, 1'b1, 32'h1C00_0600, 1'b1);
    look(32'h1C00_0020);
    // Taken update at a wrapping target, looked up from the top of the address space.
    upd (32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'h0000_0010, 1'b0);
    look(32'hFFFF_FFFC);
    look(32'hFFFF_FFF8);

    reset_mid_cycle();
    look(32'h1C00_0080);
    upd (32'h1C00_00C0, 32'h1C00_00C0, 1'b1, 32'h1C00_0400, 1'b0);
    look(32'h1C00_00C0);

    // Random traffic over a small pool of PCs so entries alias and saturate.
    for (int n = 0; n < 600; n++) begin
      r_pc = 32'h1C00_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      r_lk = ($urandom_range(0, 7) == 0) ? $urandom
           : (32'h1C00_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2));
      r_v  = ($urandom_range(0, 3) != 0);
      r_b  = ($urandom_range(0, 4) != 0);
      r_t  = $urandom_range(0, 1);
      r_m  = $urandom_range(0, 1);
      cycle(r_lk, r_v, r_b, r_pc, r_t, $urandom, r_m);
    end

    drain = 0;
    while (sb.size() > 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
